// File: rtl/bram_port_arbiter.sv
// Shares one dual-port BRAM (write port + registered read port) between two requesters.
// Optional same-word write-to-read forwarding is enabled by defining BRAM_ARB_FWD_EN.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

  // Handshake: req and its we/addr/wdata/wstrb stay stable until gnt; the
  // transaction is accepted in the cycle req && gnt, at most one per requester.
  logic                  wr_c0, wr_c1, rd_c0, rd_c1;
  logic                  wr_any, wr_sel1, rd_any, rd_sel1;
  logic                  wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, addrb_q;
  logic                  tag_v, tag_id;
  logic [31:0]           rdata_mux, m0_rdata_q, m1_rdata_q;

  assign wr_c0   = !rsta && m0_req && m0_we;
  assign wr_c1   = !rsta && m1_req && m1_we;
  assign wr_any  = wr_c0 || wr_c1;
  assign wr_sel1 = wr_c1 && (!wr_c0 || wr_ptr);
  assign wr_addr = wr_sel1 ? m1_addr : m0_addr;

`ifdef BRAM_ARB_FWD_EN
  assign rd_c0 = !rsta && m0_req && !m0_we;
  assign rd_c1 = !rsta && m1_req && !m1_we;
`else
  // A read hitting the word being written this cycle waits one cycle.
  logic hit0, hit1;
  assign hit0  = wr_any && (m0_addr == wr_addr);
  assign hit1  = wr_any && (m1_addr == wr_addr);
  assign rd_c0 = !rsta && m0_req && !m0_we && !hit0;
  assign rd_c1 = !rsta && m1_req && !m1_we && !hit1;
`endif

  assign rd_any  = rd_c0 || rd_c1;
  assign rd_sel1 = rd_c1 && (!rd_c0 || rd_ptr);
  assign rd_addr = rd_sel1 ? m1_addr : m0_addr;

  assign ram_addra = wr_addr;
  assign ram_dina  = wr_sel1 ? m1_wdata : m0_wdata;
  assign ram_wea   = !wr_any ? 4'b0000 : (wr_sel1 ? m1_wstrb : m0_wstrb);
  assign ram_addrb = rd_any ? rd_addr : addrb_q;

  assign m0_gnt = (wr_any && !wr_sel1) || (rd_any && !rd_sel1);
  assign m1_gnt = (wr_any && wr_sel1) || (rd_any && rd_sel1);

  assign m0_rvalid = tag_v && !tag_id && !rsta;
  assign m1_rvalid = tag_v && tag_id && !rsta;
  assign m0_rdata  = m0_rvalid ? rdata_mux : m0_rdata_q;
  assign m1_rdata  = m1_rvalid ? rdata_mux : m1_rdata_q;

  always_ff @(posedge clka) begin
    if (rsta) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      tag_v      <= 1'b0;
      tag_id     <= 1'b0;
      addrb_q    <= '0;
      m0_rdata_q <= 32'h0;
      m1_rdata_q <= 32'h0;
    end else begin
      // Pointer names the favoured requester; it moves to the loser only on contention.
      if (wr_c0 && wr_c1) wr_ptr <= !wr_sel1;
      if (rd_c0 && rd_c1) rd_ptr <= !rd_sel1;
      tag_v   <= rd_any;
      tag_id  <= rd_sel1;
      addrb_q <= ram_addrb;
      if (m0_rvalid) m0_rdata_q <= rdata_mux;
      if (m1_rvalid) m1_rdata_q <= rdata_mux;
    end
  end

`ifdef BRAM_ARB_FWD_EN
  // The RAM returns pre-write data on a same-word collision; patch in the written bytes.
  logic        fwd_v;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_strb;

  always_ff @(posedge clka) begin
    if (rsta) begin
      fwd_v    <= 1'b0;
      fwd_data <= 32'h0;
      fwd_strb <= 4'h0;
    end else begin
      fwd_v    <= wr_any && rd_any && (rd_addr == wr_addr);
      fwd_data <= ram_dina;
      fwd_strb <= ram_wea;
    end
  end

  always_comb begin
    rdata_mux = ram_doutb;
    if (fwd_v) begin
      for (int k = 0; k < 4; k++) begin
        if (fwd_strb[k]) rdata_mux[8*k +: 8] = fwd_data[8*k +: 8];
      end
    end
  end
`else
  assign rdata_mux = ram_doutb;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: behavioural RAM, reference model and scoreboard.
// Honours BRAM_ARB_FWD_EN to select the expected collision behaviour.
module tb_bram_port_arbiter;
  localparam int AW = 14;
`ifdef BRAM_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clka;
  logic          rsta;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdata, m0_rdata;
  logic [3:0]    m0_wstrb;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata, m1_rdata;
  logic [3:0]    m1_wstrb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [31:0]   ram_dina, ram_doutb;
  logic [3:0]    ram_wea;

  // Driver-side transaction slots, index 0 = M0, 1 = M1.
  logic          t_req[2];
  logic          t_we[2];
  logic [AW-1:0] t_addr[2];
  logic [31:0]   t_wdata[2];
  logic [3:0]    t_wstrb[2];

  assign m0_req = t_req[0]; assign m0_we = t_we[0]; assign m0_addr = t_addr[0];
  assign m0_wdata = t_wdata[0]; assign m0_wstrb = t_wstrb[0];
  assign m1_req = t_req[1]; assign m1_we = t_we[1]; assign m1_addr = t_addr[1];
  assign m1_wdata = t_wdata[1]; assign m1_wstrb = t_wstrb[1];

  bram_port_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clka(clka), .rsta(rsta),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  // ---------------- clock / reset ----------------
  initial clka = 1'b0;
  always #5 clka = ~clka;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  // Behavioural block RAM: read-before-write, registered read data.
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clka) begin
    ram_doutb <= ram[ram_addrb];
    if (ram_wea != 4'h0) ram[ram_addra] <= merge(ram[ram_addra], ram_dina, ram_wea);
  end

  // ---------------- scoreboard / model state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];                    // {requester id, expected read data}
  logic [31:0] model_mem [0:(1<<AW)-1];
  logic [31:0] last_rd[2];
  logic [AW-1:0] last_addrb;
  bit          addrb_known;
  int          wp, rp;
  bit          granted[2];
  logic        obs_gnt[2], obs_rvalid[2];
  logic [31:0] obs_rdata[2];
  logic [AW-1:0] obs_addra;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_txn(input int i, input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    t_req[i] = req; t_we[i] = we; t_addr[i] = addr; t_wdata[i] = wdata; t_wstrb[i] = wstrb;
  endtask

  task automatic idle();
    set_txn(0, 1'b0, 1'b0, '0, 32'h0, 4'h0);
    set_txn(1, 1'b0, 1'b0, '0, 32'h0, 4'h0);
  endtask

  task automatic rand_txn(input int i);
    logic [AW-1:0] a;
    if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, (1<<AW)-1));
    else a = AW'(32'h100 + $urandom_range(0, 3));
    set_txn(i, $urandom_range(0, 3) != 0, 1'(($urandom_range(0, 1))), a, $urandom,
            4'($urandom_range(0, 15)));
  endtask

  // One clock cycle: sample at negedge, compare against the model, advance the model.
  task automatic step();
    int wwin, rwin, id;
    bit wc[2], rc[2], e_rv[2];
    logic [31:0] e_rd[2], d;
    logic [AW-1:0] e_addrb;
    @(negedge clka);
    obs_gnt[0] = m0_gnt; obs_gnt[1] = m1_gnt;
    obs_rvalid[0] = m0_rvalid; obs_rvalid[1] = m1_rvalid;
    obs_rdata[0] = m0_rdata; obs_rdata[1] = m1_rdata;
    obs_addra = ram_addra;
    wwin = -1; rwin = -1;
    if (!rsta) begin
      for (int i = 0; i < 2; i++) wc[i] = t_req[i] && t_we[i];
      if (wc[0] && wc[1]) begin wwin = wp; wp = 1 - wwin; end
      else if (wc[0]) wwin = 0;
      else if (wc[1]) wwin = 1;
      for (int i = 0; i < 2; i++)
        rc[i] = t_req[i] && !t_we[i] && (FWD || wwin < 0 || t_addr[i] != t_addr[wwin]);
      if (rc[0] && rc[1]) begin rwin = rp; rp = 1 - rwin; end
      else if (rc[0]) rwin = 0;
      else if (rc[1]) rwin = 1;
    end
    for (int i = 0; i < 2; i++) begin e_rv[i] = 1'b0; e_rd[i] = last_rd[i]; end
    if (!rsta && exp_q.size() > 0) begin
      id = int'(exp_q[0][32]);
      e_rv[id] = 1'b1;
      e_rd[id] = exp_q[0][31:0];
    end
    check("m0_gnt", 32'(m0_gnt), 32'(wwin == 0 || rwin == 0));
    check("m1_gnt", 32'(m1_gnt), 32'(wwin == 1 || rwin == 1));
    check("ram_wea", 32'(ram_wea), (wwin >= 0) ? 32'(t_wstrb[wwin]) : 32'h0);
    if (wwin >= 0) begin
      check("ram_addra", 32'(ram_addra), 32'(t_addr[wwin]));
      check("ram_dina", ram_dina, t_wdata[wwin]);
    end
    e_addrb = (rwin >= 0) ? t_addr[rwin] : last_addrb;
    if (rwin >= 0 || (!rsta && addrb_known)) check("ram_addrb", 32'(ram_addrb), 32'(e_addrb));
    check("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
    check("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
    check("m0_rdata", m0_rdata, e_rd[0]);
    check("m1_rdata", m1_rdata, e_rd[1]);
    if (rsta) begin
      exp_q.delete();
      last_rd[0] = 32'h0; last_rd[1] = 32'h0;
      wp = 0; rp = 0;
      granted[0] = 1'b0; granted[1] = 1'b0;
      addrb_known = 1'b0;
    end else begin
      if (exp_q.size() > 0) begin
        id = int'(exp_q[0][32]);
        last_rd[id] = exp_q[0][31:0];
        void'(exp_q.pop_front());
      end
      if (rwin >= 0) begin
        d = model_mem[t_addr[rwin]];
        if (wwin >= 0 && t_addr[wwin] == t_addr[rwin]) d = merge(d, t_wdata[wwin], t_wstrb[wwin]);
        exp_q.push_back({1'(rwin), d});
        last_addrb = e_addrb;
        addrb_known = 1'b1;
      end
      if (wwin >= 0) model_mem[t_addr[wwin]] = merge(model_mem[t_addr[wwin]], t_wdata[wwin], t_wstrb[wwin]);
      for (int i = 0; i < 2; i++) granted[i] = (wwin == i) || (rwin == i);
    end
    @(posedge clka); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int a = 0; a < (1<<AW); a++) begin ram[a] = 32'h0; model_mem[a] = 32'h0; end
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    last_addrb = '0; addrb_known = 1'b0; wp = 0; rp = 0;
    idle();
    rsta = 1'b1;
    @(posedge clka); #1;

    // Reset with requests pending: nothing granted, nothing written.
    set_txn(0, 1'b1, 1'b0, 14'h010, 32'h0, 4'h0);
    set_txn(1, 1'b1, 1'b1, 14'h020, 32'h55, 4'hF);
    repeat (3) begin
      step();
      check("rst_gnt0", 32'(obs_gnt[0]), 32'h0);
      check("rst_rdata0", obs_rdata[0], 32'h0);
    end
    rsta = 1'b0; idle();
    step();

    // Write then read back.
    set_txn(0, 1'b1, 1'b1, 14'h010, 32'hDEADBEEF, 4'hF);
    step(); check("wr_gnt", 32'(obs_gnt[0]), 32'h1);
    set_txn(0, 1'b1, 1'b0, 14'h010, 32'h0, 4'h0);
    step(); check("rd_gnt", 32'(obs_gnt[0]), 32'h1);
    idle();
    step(); check("rd_rvalid", 32'(obs_rvalid[0]), 32'h1);
    check("rd_data", obs_rdata[0], 32'hDEADBEEF);
    step(); check("rd_rvalid_once", 32'(obs_rvalid[0]), 32'h0);

    // Read contention: alternating grants, rvalid one cycle behind.
    set_txn(0, 1'b1, 1'b0, 14'h010, 32'h0, 4'h0);
    set_txn(1, 1'b1, 1'b0, 14'h011, 32'h0, 4'h0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("rd_alt_gnt0", 32'(obs_gnt[0]), 32'(c % 2 == 0));
      check("rd_alt_gnt1", 32'(obs_gnt[1]), 32'(c % 2 == 1));
      if (c > 0) check("rd_alt_rvalid", 32'(obs_rvalid[(c - 1) % 2]), 32'h1);
    end
    idle();
    step(); check("rd_alt_last_rvalid", 32'(obs_rvalid[1]), 32'h1);

    // Write contention: alternation visible on the RAM write port.
    set_txn(0, 1'b1, 1'b1, 14'h030, 32'h12345678, 4'hF);
    set_txn(1, 1'b1, 1'b1, 14'h031, 32'h9ABCDEF0, 4'hF);
    for (int c = 0; c < 4; c++) begin
      step();
      check("wr_alt_gnt0", 32'(obs_gnt[0]), 32'(c % 2 == 0));
      check("wr_alt_addra", 32'(obs_addra), (c % 2 == 0) ? 32'h030 : 32'h031);
    end
    idle(); step();

    // Parallel write and read from different requesters.
    set_txn(0, 1'b1, 1'b1, 14'h020, 32'hCAFEF00D, 4'hF);
    set_txn(1, 1'b1, 1'b0, 14'h030, 32'h0, 4'h0);
    step();
    check("par_gnt0", 32'(obs_gnt[0]), 32'h1);
    check("par_gnt1", 32'(obs_gnt[1]), 32'h1);
    idle();
    step(); check("par_rdata1", obs_rdata[1], 32'h12345678);

    // Same-word collision.
    set_txn(0, 1'b1, 1'b1, 14'h040, 32'h11223344, 4'hF);
    step(); idle();
    set_txn(0, 1'b1, 1'b1, 14'h040, 32'hAABBCCDD, 4'h3);
    set_txn(1, 1'b1, 1'b0, 14'h040, 32'h0, 4'h0);
    step();
    check("col_gnt0", 32'(obs_gnt[0]), 32'h1);
`ifdef BRAM_ARB_FWD_EN
    check("col_gnt1_fwd", 32'(obs_gnt[1]), 32'h1);
    idle();
    step();
`else
    check("col_gnt1_stall", 32'(obs_gnt[1]), 32'h0);
    set_txn(0, 1'b0, 1'b0, '0, 32'h0, 4'h0);
    step(); check("col_gnt1_retry", 32'(obs_gnt[1]), 32'h1);
    idle();
    step();
`endif
    check("col_rvalid1", 32'(obs_rvalid[1]), 32'h1);
    check("col_rdata1", obs_rdata[1], 32'h1122CCDD);

    // Zero-strobe write is granted but leaves the word alone.
    set_txn(0, 1'b1, 1'b1, 14'h040, 32'hFFFFFFFF, 4'h0);
    step(); check("zstrb_gnt", 32'(obs_gnt[0]), 32'h1);
    set_txn(0, 1'b1, 1'b0, 14'h040, 32'h0, 4'h0);
    step(); idle();
    step(); check("zstrb_rdata", obs_rdata[0], 32'h1122CCDD);

    // Move both pointers to M1, then reset while M1 issues a read.
    set_txn(0, 1'b1, 1'b0, 14'h010, 32'h0, 4'h0);
    set_txn(1, 1'b1, 1'b0, 14'h011, 32'h0, 4'h0);
    step();
    set_txn(0, 1'b1, 1'b1, 14'h050, 32'h1, 4'hF);
    set_txn(1, 1'b1, 1'b1, 14'h051, 32'h2, 4'hF);
    step();
    idle();
    set_txn(1, 1'b1, 1'b0, 14'h010, 32'h0, 4'h0);
    rsta = 1'b1;
    step(); check("rstmid_gnt1", 32'(obs_gnt[1]), 32'h0);
    rsta = 1'b0; idle();
    step(); check("rstmid_rvalid1", 32'(obs_rvalid[1]), 32'h0);
    set_txn(0, 1'b1, 1'b0, 14'h010, 32'h0, 4'h0);
    set_txn(1, 1'b1, 1'b0, 14'h011, 32'h0, 4'h0);
    step(); check("rstmid_rdptr", 32'(obs_gnt[0]), 32'h1);
    idle(); step();
    set_txn(0, 1'b1, 1'b1, 14'h050, 32'h3, 4'hF);
    set_txn(1, 1'b1, 1'b1, 14'h051, 32'h4, 4'hF);
    step(); check("rstmid_wrptr", 32'(obs_gnt[0]), 32'h1);
    idle(); step();

    // Randomized traffic with occasional resets; requests held until granted.
    repeat (600) begin
      for (int i = 0; i < 2; i++) if (!t_req[i] || granted[i]) rand_txn(i);
      rsta = ($urandom_range(0, 99) < 2);
      step();
    end
    rsta = 1'b0; idle();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
